// File: rtl/synaptic_current_driver.sv
// Synaptic current integrator: queues presynaptic spike events, applies one per cycle,
// leaks the current by a shift on every timestep tick, and clamps to the 16-bit range.
module synaptic_current_driver #(
  parameter int unsigned DECAY_SHIFT = 3,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spike_valid,
  output logic        spike_ready,
  input  logic [15:0] spike_weight,
  input  logic        spike_inhibit,
  input  logic        tick,
  input  logic        freeze,
  input  logic        sat_clear,
  output logic [15:0] input_current,
  output logic        saturated,
  output logic [7:0]  events_last_tick
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  logic [15:0]     weight_mem  [FIFO_DEPTH];
  logic            inhibit_mem [FIFO_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [15:0]     cur_q, cur_d;
  logic            sat_q, sat_d;
  logic [7:0]      ev_cnt_q, ev_cnt_d;
  logic [7:0]      elt_q, elt_d;

  logic            push, pop, do_tick, clamp;
  logic [15:0]     head_w, decayed;
  logic            head_inh;
  logic [7:0]      ev_cnt_inc;
  logic signed [17:0] sum;

  assign spike_ready      = (count_q < DepthCnt);
  assign input_current    = cur_q;
  assign saturated        = sat_q;
  assign events_last_tick = elt_q;

  always_comb begin
    push     = spike_valid & spike_ready;
    pop      = ~freeze & (count_q != '0);
    do_tick  = tick & ~freeze;
    head_w   = weight_mem[rd_ptr_q];
    head_inh = inhibit_mem[rd_ptr_q];

    // Leak is computed before the event so a coincident pop lands on the decayed value.
    decayed = do_tick ? (cur_q - (cur_q >> DECAY_SHIFT)) : cur_q;
    sum     = $signed({2'b00, decayed});
    if (pop) begin
      if (head_inh) sum = sum - $signed({2'b00, head_w});
      else          sum = sum + $signed({2'b00, head_w});
    end

    clamp = 1'b0;
    cur_d = sum[15:0];
    if (sum > 18'sd65535) begin
      cur_d = 16'hffff;
      clamp = 1'b1;
    end else if (sum < 18'sd0) begin
      cur_d = 16'h0000;
      clamp = 1'b1;
    end

    if (clamp)          sat_d = 1'b1;
    else if (sat_clear) sat_d = 1'b0;
    else                sat_d = sat_q;

    ev_cnt_inc = (pop && ev_cnt_q != 8'hff) ? ev_cnt_q + 8'd1 : ev_cnt_q;
    if (do_tick) begin
      elt_d    = ev_cnt_inc;
      ev_cnt_d = 8'd0;
    end else begin
      elt_d    = elt_q;
      ev_cnt_d = ev_cnt_inc;
    end

    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cur_q    <= '0;
      sat_q    <= 1'b0;
      ev_cnt_q <= '0;
      elt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cur_q    <= cur_d;
      sat_q    <= sat_d;
      ev_cnt_q <= ev_cnt_d;
      elt_q    <= elt_d;
    end
  end

  // Storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      weight_mem[wr_ptr_q]  <= spike_weight;
      inhibit_mem[wr_ptr_q] <= spike_inhibit;
    end
  end

endmodule

// File: tb/tb_synaptic_current_driver.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against an event-queue model of the synapse.
module tb_synaptic_current_driver;

  localparam int Shift = 3;
  localparam int Depth = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        spike_valid = 1'b0;
  logic        spike_ready;
  logic [15:0] spike_weight = '0;
  logic        spike_inhibit = 1'b0;
  logic        tick = 1'b0;
  logic        freeze = 1'b0;
  logic        sat_clear = 1'b0;
  logic [15:0] input_current;
  logic        saturated;
  logic [7:0]  events_last_tick;

  synaptic_current_driver #(
    .DECAY_SHIFT(Shift),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .spike_valid     (spike_valid),
    .spike_ready     (spike_ready),
    .spike_weight    (spike_weight),
    .spike_inhibit   (spike_inhibit),
    .tick            (tick),
    .freeze          (freeze),
    .sat_clear       (sat_clear),
    .input_current   (input_current),
    .saturated       (saturated),
    .events_last_tick(events_last_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Reference model: a queue of pending events and plain integer arithmetic.
  typedef struct {int w; bit inh;} ev_t;
  ev_t q[$];
  int  m_cur = 0;
  bit  m_sat = 0;
  int  m_cnt = 0;
  int  m_elt = 0;

  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      m_cur = 0; m_sat = 0; m_cnt = 0; m_elt = 0;
    end else begin
      bit accept, popping, dt, clamped;
      int n;
      ev_t e;
      accept  = spike_valid && (q.size() < Depth);
      popping = !freeze && (q.size() > 0);
      dt      = tick && !freeze;
      n       = dt ? m_cur - (m_cur >> Shift) : m_cur;
      if (popping) begin
        e = q.pop_front();
        n = e.inh ? n - e.w : n + e.w;
        if (m_cnt < 255) m_cnt++;
      end
      clamped = 0;
      if (n > 65535) begin n = 65535; clamped = 1; end
      if (n < 0)     begin n = 0;     clamped = 1; end
      m_cur = n;
      if (clamped) m_sat = 1;
      else if (sat_clear) m_sat = 0;
      if (dt) begin m_elt = m_cnt; m_cnt = 0; end
      if (accept) begin
        e.w = int'(spike_weight); e.inh = spike_inhibit;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_current", int'(input_current), m_cur);
      chk("model_saturated", int'(saturated), int'(m_sat));
      chk("model_events_last_tick", int'(events_last_tick), m_elt);
      chk("model_spike_ready", int'(spike_ready), int'(q.size() < Depth));
    end
  end

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    spike_valid = 0; tick = 0; sat_clear = 0;
  endtask

  task automatic push(input int w, input bit inh);
    spike_valid = 1; spike_weight = 16'(w); spike_inhibit = inh;
  endtask

  // Push one event, then idle one edge so it is applied.
  task automatic apply(input int w, input bit inh);
    push(w, inh);
    edge_();
    idle();
    edge_();
  endtask

  initial begin
    reset = 0;
    edge_();
    chk_en = 1;
    edge_();
    chk("reset_current", int'(input_current), 0);
    chk("reset_ready", int'(spike_ready), 1);
    chk("reset_sat", int'(saturated), 0);
    chk("reset_elt", int'(events_last_tick), 0);
    reset = 1;

    // Single event and its latency.
    push(10000, 0);
    edge_();
    idle();
    chk("single_not_yet", int'(input_current), 0);
    edge_();
    chk("single_applied", int'(input_current), 10000);
    tick = 1;
    edge_();
    idle();
    chk("single_elt", int'(events_last_tick), 1);
    chk("decay_alone", int'(input_current), 8750);

    // Decay with a coincident pop.
    apply(750, 1);
    chk("to_8000", int'(input_current), 8000);
    push(1000, 0);
    edge_();
    idle();
    tick = 1;
    edge_();
    idle();
    chk("decay_plus_pop", int'(input_current), 8000);
    chk("decay_pop_elt", int'(events_last_tick), 2);

    // Clamping and sticky saturation.
    apply(52000, 0);
    chk("to_60000", int'(input_current), 60000);
    apply(10000, 0);
    chk("clamp_hi", int'(input_current), 65535);
    chk("clamp_hi_sat", int'(saturated), 1);
    apply(64535, 1);
    chk("to_1000", int'(input_current), 1000);
    apply(3000, 1);
    chk("clamp_lo", int'(input_current), 0);
    chk("clamp_lo_sat", int'(saturated), 1);
    sat_clear = 1;
    edge_();
    idle();
    chk("sat_cleared", int'(saturated), 0);

    // Backpressure while frozen.
    freeze = 1;
    for (int i = 1; i <= 4; i++) begin
      push(100 * i, 0);
      edge_();
    end
    chk("bp_full_ready", int'(spike_ready), 0);
    push(5000, 0);
    edge_();
    idle();
    chk("bp_5th_ready", int'(spike_ready), 0);
    freeze = 0;
    edge_();
    chk("bp_pop1", int'(input_current), 100);
    chk("bp_ready_after_pop", int'(spike_ready), 1);
    edge_();
    chk("bp_pop2", int'(input_current), 300);
    edge_();
    chk("bp_pop3", int'(input_current), 600);
    edge_();
    chk("bp_pop4", int'(input_current), 1000);
    edge_();
    chk("bp_no_5th", int'(input_current), 1000);

    // Reset discards queued events.
    apply(4000, 0);
    chk("to_5000", int'(input_current), 5000);
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      push(111, 0);
      edge_();
    end
    push(222, 0);
    reset = 0;
    edge_();
    reset = 1;
    idle();
    chk("rst_mid_current", int'(input_current), 0);
    chk("rst_mid_ready", int'(spike_ready), 1);
    freeze = 0;
    edge_();
    edge_();
    edge_();
    chk("rst_mid_stays0", int'(input_current), 0);

    // Counter saturation.
    tick = 1;
    edge_();
    idle();
    for (int i = 0; i < 300; i++) begin
      push(0, 0);
      edge_();
    end
    idle();
    edge_();
    tick = 1;
    edge_();
    idle();
    chk("cnt_sat_elt", int'(events_last_tick), 255);
    chk("cnt_sat_current", int'(input_current), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      spike_valid   = ($urandom_range(0, 9) < 7);
      spike_weight  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535))
                                                  : 16'($urandom_range(0, 2000));
      spike_inhibit = ($urandom_range(0, 2) == 0);
      tick          = ($urandom_range(0, 9) == 0);
      freeze        = ($urandom_range(0, 99) < 15);
      sat_clear     = ($urandom_range(0, 19) == 0);
      reset         = ($urandom_range(0, 199) != 0);
      edge_();
    end
    reset = 1;
    idle();
    freeze = 0;
    edge_();
    edge_();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
